// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline control unit for the five-stage RISC-V core.
//
// Merges stall requests from IF, ID and MEM into a monotone per-stage stall
// bus, and turns taken-jump pulses from EX into the ex_flag flush line. A small
// three-state sequencer keeps the flush effective when it collides with a
// frozen EX stage (PEND) or an in-flight fetch whose data is stale (DISCARD).
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   if_stall_req   in   IF fetch outstanding
//   id_stall_req   in   load-use hazard in ID
//   mem_stall_req  in   MEM access outstanding
//   ex_jump        in   one-cycle pulse: EX resolved a taken branch/jump
//   stall          out  [STALL_W-1:0] per-stage hold (bit0 PC .. bit5 WB)
//   ex_flag        out  flush of IF/ID and ID/EX, PC takes jump target
//   if_discard     out  IF drops the data of the fetch completing this cycle
//
// Optional feature (macro PIPE_CTRL_PERF_EN):
//   perf_stall_cycles out [31:0] cycles with stall[STALL_ID] set
//   perf_flush_cnt    out [31:0] cycles with ex_flag set
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_stall_req,
    input  logic               id_stall_req,
    input  logic               mem_stall_req,
    input  logic               ex_jump,
    output logic [STALL_W-1:0] stall,
    output logic               ex_flag,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flush_cnt,
`endif
    output logic               if_discard
);

    localparam int STALL_ID = 2;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PEND    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   flag_s;
    logic   discard_s;

    // Sequencer next-state and flush/discard decode
    always_comb begin
        state_d   = state_q;
        flag_s    = 1'b0;
        discard_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_jump && mem_stall_req) begin
                    // ID/EX honours its hold before the flush, so defer it
                    state_d = ST_PEND;
                end else if (ex_jump) begin
                    flag_s  = 1'b1;
                    state_d = if_stall_req ? ST_DISCARD : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                // EX is frozen here, so a new ex_jump cannot be genuine
                if (!mem_stall_req) begin
                    flag_s  = 1'b1;
                    state_d = if_stall_req ? ST_DISCARD : ST_RUN;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_DISCARD: begin
                discard_s = 1'b1;
                if (ex_jump && mem_stall_req) begin
                    state_d = ST_PEND;
                end else if (ex_jump) begin
                    flag_s  = 1'b1;
                    state_d = ST_DISCARD;
                end else if (!if_stall_req) begin
                    // stale fetch completes this cycle; it is dropped now
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Stall bus: monotone, MEM > ID (masked by a flush) > IF
    always_comb begin
        stall = '0;
        if (mem_stall_req) begin
            stall[4:0] = 5'b11111;
        end else if (id_stall_req && !flag_s) begin
            stall[2:0] = 3'b111;
        end else if (if_stall_req) begin
            stall[1:0] = 2'b11;
        end else begin
            stall = '0;
        end
    end

    assign ex_flag    = flag_s;
    assign if_discard = discard_s;

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Performance counters, wrapping modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall[STALL_ID]) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flag_s) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_cnt    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl.
// The reference model tracks two booleans: "a flush is owed" and "the current
// fetch is stale", and derives all outputs from the request priority rules.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_stall_req;
    logic       id_stall_req;
    logic       mem_stall_req;
    logic       ex_jump;
    logic [5:0] stall;
    logic       ex_flag;
    logic       if_discard;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit          owe_flush;
    bit          stale_fetch;
    int unsigned ref_stall_cnt;
    int unsigned ref_flush_cnt;

    pipe_ctrl #(.STALL_W(6)) dut (
        .clk               (clk),
        .rst               (rst),
        .if_stall_req      (if_stall_req),
        .id_stall_req      (id_stall_req),
        .mem_stall_req     (mem_stall_req),
        .ex_jump           (ex_jump),
        .stall             (stall),
        .ex_flag           (ex_flag),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cnt    (perf_flush_cnt),
`endif
        .if_discard        (if_discard)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owe_flush     = 1'b0;
        stale_fetch   = 1'b0;
        ref_stall_cnt = 0;
        ref_flush_cnt = 0;
    endtask

    // Apply one cycle of inputs, compare outputs, advance the model
    task automatic step(input bit m, input bit i, input bit d, input bit j, input string tag);
        bit         e_flag;
        logic [5:0] e_stall;
        @(negedge clk);
        mem_stall_req = m;
        if_stall_req  = i;
        id_stall_req  = d;
        ex_jump       = j;
        #1;
        if (owe_flush) e_flag = !m;
        else           e_flag = j && !m;
        if (m)                  e_stall = 6'b011111;
        else if (d && !e_flag)  e_stall = 6'b000111;
        else if (i)             e_stall = 6'b000011;
        else                    e_stall = 6'b000000;
        check_val({tag, ".stall"},   {26'd0, stall},      {26'd0, e_stall});
        check_val({tag, ".flag"},    {31'd0, ex_flag},    {31'd0, e_flag});
        check_val({tag, ".discard"}, {31'd0, if_discard}, {31'd0, stale_fetch});
        if (e_stall[2]) ref_stall_cnt++;
        if (e_flag)     ref_flush_cnt++;
        // advance the model
        if (owe_flush) begin
            if (!m) begin
                owe_flush   = 1'b0;
                stale_fetch = i;
            end
        end else if (j && m) begin
            owe_flush   = 1'b1;
            stale_fetch = 1'b0;
        end else if (j) begin
            stale_fetch = stale_fetch || i;
        end else if (stale_fetch && !i) begin
            stale_fetch = 1'b0;
        end
    endtask

    initial begin
        rst           = 1'b1;
        if_stall_req  = 1'b0;
        id_stall_req  = 1'b0;
        mem_stall_req = 1'b0;
        ex_jump       = 1'b0;
        model_reset();
        #1;
        check_val("rst.stall",   {26'd0, stall},      32'd0);
        check_val("rst.flag",    {31'd0, ex_flag},    32'd0);
        check_val("rst.discard", {31'd0, if_discard}, 32'd0);
        mem_stall_req = 1'b1;
        #1;
        check_val("rst.stall_mem", {26'd0, stall}, 32'h1f);
        mem_stall_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // request priority patterns
        step(1'b1, 1'b0, 1'b0, 1'b0, "req_mem");
        step(1'b0, 1'b0, 1'b1, 1'b0, "req_id");
        step(1'b0, 1'b1, 1'b0, 1'b0, "req_if");
        step(1'b0, 1'b0, 1'b0, 1'b0, "req_none");
        step(1'b1, 1'b1, 1'b1, 1'b0, "req_all");
        step(1'b0, 1'b1, 1'b1, 1'b0, "req_id_if");

        // plain jump
        step(1'b0, 1'b0, 1'b0, 1'b1, "jmp");
        step(1'b0, 1'b0, 1'b0, 1'b0, "jmp_after");

        // jump against a MEM stall lasting 3 more cycles
        step(1'b1, 1'b0, 1'b0, 1'b1, "pend0");
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 1'b0, "pend_hold");
        step(1'b0, 1'b0, 1'b0, 1'b0, "pend_release");
        step(1'b0, 1'b0, 1'b0, 1'b0, "pend_after");

        // jump during a 4-cycle fetch
        step(1'b0, 1'b1, 1'b0, 1'b1, "disc0");
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0, "disc_hold");
        step(1'b0, 1'b0, 1'b0, 1'b0, "disc_fall");
        step(1'b0, 1'b0, 1'b0, 1'b0, "disc_after");

        // jump with a load-use hazard
        step(1'b0, 1'b0, 1'b1, 1'b1, "jmp_id");
        step(1'b0, 1'b1, 1'b1, 1'b1, "jmp_id_if");
        step(1'b0, 1'b0, 1'b0, 1'b0, "jmp_id_if_fall");

        // new jump in DISCARD while MEM busy, then release
        step(1'b0, 1'b1, 1'b0, 1'b1, "dj0");
        step(1'b1, 1'b1, 1'b0, 1'b1, "dj_mem");
        step(1'b0, 1'b0, 1'b0, 1'b0, "dj_release");
        step(1'b0, 1'b0, 1'b0, 1'b0, "dj_after");

        // reset while a flush is owed: it must be dropped
        step(1'b1, 1'b0, 1'b0, 1'b1, "rpend0");
        @(negedge clk);
        mem_stall_req = 1'b0;
        ex_jump       = 1'b0;
        rst           = 1'b1;
        #1;
        check_val("rpend.flag",    {31'd0, ex_flag},    32'd0);
        check_val("rpend.discard", {31'd0, if_discard}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b0, "rpend_after");

        // three flushes for the counters
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, "cnt_jmp");
            step(1'b0, 1'b0, 1'b0, 1'b0, "cnt_gap");
        end
`ifdef PIPE_CTRL_PERF_EN
        check_val("perf_flush3", perf_flush_cnt, 32'd3);
`endif

        // randomized traffic with sticky requests and sparse jump pulses
        begin
            bit m = 1'b0, i = 1'b0, d = 1'b0, j;
            for (int n = 0; n < 2000; n++) begin
                if ($urandom_range(0, 3) == 0) m = ~m;
                if ($urandom_range(0, 2) == 0) i = ~i;
                if ($urandom_range(0, 4) == 0) d = ~d;
                j = ($urandom_range(0, 4) == 0);
                step(m, i, d, j, "rnd");
            end
        end

`ifdef PIPE_CTRL_PERF_EN
        #1;
        check_val("perf_stall", perf_stall_cycles, ref_stall_cnt);
        check_val("perf_flush", perf_flush_cnt,    ref_flush_cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage RISC-V core. It collects stall requests from IF, ID and MEM, plus taken-jump notifications from EX. From these it drives the shared stall bus and the `ex_flag` flush line that the IF/ID and ID/EX pipeline registers consume. It also owns the sequencing rules that keep a flush effective when it coincides with a frozen EX stage or an in-flight instruction fetch.

## Interface
Parameters:
- `STALL_W`, default 6: stall bus width; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB (`Stall_ID` = 2, `Stall_EX` = 3).

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `if_stall_req` input 1: IF fetch is outstanding on the memory port.
- `id_stall_req` input 1: load-use hazard detected in ID.
- `mem_stall_req` input 1: MEM access is outstanding.
- `ex_jump` input 1: single-cycle pulse; EX resolved a taken branch or jump.
- `stall` output `STALL_W`: per-stage hold; bit k = 1 means stage k's output register holds.
- `ex_flag` output 1: flush; IF/ID and ID/EX load bubbles and PC takes the jump target.
- `if_discard` output 1: IF must drop the data of the fetch completing this cycle.

## Operation
- **Stall vector** is combinational and always monotone (bit k set implies all lower bits set). Priority order:
  - `mem_stall_req` = 1: `stall` = 6'b011111.
  - else `id_stall_req` = 1 and `ex_flag` = 0: `stall` = 6'b000111. EX receives a bubble.
  - else `if_stall_req` = 1: `stall` = 6'b000011. ID receives a bubble.
  - else: `stall` = 0.
- **States:** RUN, PEND, DISCARD. A 2-bit registered state.
- **RUN:**
  - `ex_jump` with `mem_stall_req` = 0: `ex_flag` = 1 in the same cycle. If `if_stall_req` = 1, also go to DISCARD; otherwise stay in RUN.
  - `ex_jump` with `mem_stall_req` = 1: `ex_flag` = 0 and go to PEND. The flush would be ignored because ID/EX checks `stall[Stall_EX]` first.
- **PEND:**
  - `ex_flag` = 0 while `mem_stall_req` = 1.
  - In the first cycle `mem_stall_req` = 0: `ex_flag` = 1. Next state is DISCARD if `if_stall_req` = 1, else RUN.
  - `ex_jump` is ignored in PEND because EX is frozen.
- **DISCARD:**
  - `if_discard` = 1 in every DISCARD cycle, including the cycle `if_stall_req` falls (the completing stale fetch).
  - Return to RUN on the cycle after `if_stall_req` = 0 is sampled.
  - A new `ex_jump` in DISCARD asserts `ex_flag` again and stays in DISCARD. It goes to PEND if `mem_stall_req` = 1.
- `ex_flag` is never asserted for more than one consecutive cycle per jump.
- `if_discard` = 0 outside DISCARD.

## Timing
- Reset values: state = RUN, `ex_flag` = 0, `if_discard` = 0. `stall` follows the request inputs with state RUN.
- Reset mid-PEND or mid-DISCARD: the pending flush or discard is dropped immediately (asynchronous reset).
- `stall`, `ex_flag` and `if_discard` are combinational from inputs and state: zero-cycle latency in RUN.
- Flush latency from `ex_jump` in PEND is N+1 cycles, where N is the remaining `mem_stall_req` cycles.
- `ex_jump` together with `id_stall_req`: the flush wins and the ID stall is masked that cycle.

## Configuration
- `PIPE_CTRL_PERF_EN`: when defined, two extra outputs are added:
  - `perf_stall_cycles` (32-bit): increments every cycle `stall[Stall_ID]` = 1.
  - `perf_flush_cnt` (32-bit): increments on every `ex_flag` cycle.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, the ports and counters are absent and the behaviour above is unchanged.

## Test plan
- Requests: `mem_stall_req`=1 -> `stall`=6'b011111. `id_stall_req`=1 -> 6'b000111. `if_stall_req`=1 -> 6'b000011. None -> 0.
- `ex_jump` pulse with no stall -> `ex_flag`=1 for exactly 1 cycle; state remains RUN.
- `ex_jump` while `mem_stall_req`=1 for 3 more cycles -> `ex_flag`=0 during those cycles, then `ex_flag`=1 in the first cycle with `mem_stall_req`=0.
- `ex_jump` while `if_stall_req`=1 for 4 cycles -> `ex_flag`=1 once, `if_discard`=1 through the cycle `if_stall_req` drops, then 0.
- `ex_jump` plus `id_stall_req` in the same cycle -> `ex_flag`=1 and `stall`=0 (or 6'b000011 if IF is busy).
- Assert `rst` in PEND -> outputs return to reset values immediately, with no later `ex_flag`. With `PIPE_CTRL_PERF_EN`, `perf_flush_cnt` counts 3 after 3 flushes.
